mc_ctrl_int: RTL and testbench

- Multicycle MIPS-subset control unit; the next generation of the existing CPU controller.
- Adds memory wait-state handling with a timeout, a vectored interrupt entry/return (EPC, IE), overflow write suppression and a parametrised state-code width.
- Sits between the datapath (zero, overflow, instruction register) and the memory/IO bus (MIO_ready). Drives every datapath control strobe.

---
 rtl/mc_ctrl_int.sv | 277 +++++++++++++++++++++++++++
 tb/tb_mc_ctrl_int.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_int.sv
// Multicycle MIPS-subset control unit with memory wait-state timeout,
// vectored interrupt entry/return and overflow write suppression.
module mc_ctrl_int #(
  parameter int STATE_W    = 5,
  parameter int WAIT_MAX   = 16,
  parameter bit INT_EN_RST = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        Inst_in,
  input  logic               zero,
  input  logic               overflow,
  input  logic               MIO_ready,
  input  logic               INT,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               CPU_MIO,
  output logic               IorD,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               Branch,
  output logic [1:0]         RegDst,
  output logic [1:0]         MemtoReg,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSource,
  output logic [2:0]         ALU_operation,
  output logic               EPCWrite,
  output logic               VecSel,
  output logic               int_ack,
  output logic               bus_fault,
  output logic [STATE_W-1:0] state_out
);

  localparam int CNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [4:0] {
    S_IF    = 5'd0,  S_ID   = 5'd1,  S_MA   = 5'd2,  S_MRD  = 5'd3,
    S_MWB   = 5'd4,  S_MWR  = 5'd5,  S_EXR  = 5'd6,  S_WBR  = 5'd7,
    S_BEQ   = 5'd8,  S_BNE  = 5'd9,  S_J    = 5'd10, S_JAL  = 5'd11,
    S_JR    = 5'd12, S_EXI  = 5'd13, S_WBI  = 5'd14, S_LUI  = 5'd15,
    S_INT   = 5'd16, S_ERET = 5'd17, S_FAULT = 5'd18
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  state_t           w_done_next;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_ie;
  logic             r_pending;
  logic             r_bus_fault;
  logic             w_wait_state;
  logic             w_timeout;
  logic             w_wait_inc;
  logic             w_take_int;
  logic [5:0]       w_op;
  logic [5:0]       w_funct;
  logic             w_unused_bits;

  assign w_op          = Inst_in[31:26];
  assign w_funct       = Inst_in[5:0];
  assign w_unused_bits = ^{zero, Inst_in[25:6]};

  assign w_wait_state = (r_state == S_IF) || (r_state == S_MRD) || (r_state == S_MWR);
  assign w_timeout    = w_wait_state && !MIO_ready && (r_wait_cnt == CNT_W'(WAIT_MAX - 1));
  assign w_wait_inc   = w_wait_state && !MIO_ready && !w_timeout;
  // A request arriving in the completion cycle itself is honoured immediately.
  assign w_done_next  = ((r_pending || INT) && r_ie) ? S_INT : S_IF;
  assign w_take_int   = (w_state_next == S_INT);

  always_comb begin
    w_state_next = S_IF;
    case (r_state)
      S_IF: begin
        if (MIO_ready)      w_state_next = S_ID;
        else if (w_timeout) w_state_next = S_FAULT;
        else                w_state_next = S_IF;
      end
      S_ID: begin
        case (w_op)
          6'h00:                      w_state_next = (w_funct == 6'h08) ? S_JR : S_EXR;
          6'h23, 6'h2B:               w_state_next = S_MA;
          6'h04:                      w_state_next = S_BEQ;
          6'h05:                      w_state_next = S_BNE;
          6'h02:                      w_state_next = S_J;
          6'h03:                      w_state_next = S_JAL;
          6'h08, 6'h0C, 6'h0D, 6'h0A: w_state_next = S_EXI;
          6'h0F:                      w_state_next = S_LUI;
          6'h10:                      w_state_next = (w_funct == 6'h18) ? S_ERET : S_IF;
          default:                    w_state_next = S_IF;
        endcase
      end
      S_MA:  w_state_next = (w_op == 6'h2B) ? S_MWR : S_MRD;
      S_MRD: begin
        if (MIO_ready)      w_state_next = S_MWB;
        else if (w_timeout) w_state_next = S_FAULT;
        else                w_state_next = S_MRD;
      end
      S_MWR: begin
        if (MIO_ready)      w_state_next = w_done_next;
        else if (w_timeout) w_state_next = S_FAULT;
        else                w_state_next = S_MWR;
      end
      S_EXR:   w_state_next = S_WBR;
      S_EXI:   w_state_next = S_WBI;
      S_MWB, S_WBR, S_WBI, S_LUI, S_BEQ, S_BNE,
      S_J, S_JAL, S_JR, S_ERET:
               w_state_next = w_done_next;
      S_INT:   w_state_next = S_IF;
      S_FAULT: w_state_next = S_FAULT;
      default: w_state_next = S_IF;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IF;
      r_ie        <= INT_EN_RST;
      r_wait_cnt  <= '0;
      r_pending   <= 1'b0;
      r_bus_fault <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_inc ? (r_wait_cnt + CNT_W'(1)) : '0;
      if (w_timeout)
        r_bus_fault <= 1'b1;
      if (w_take_int)
        r_pending <= 1'b0;
      else if (INT)
        r_pending <= 1'b1;
      if (r_state == S_INT)
        r_ie <= 1'b0;
      else if (r_state == S_ERET)
        r_ie <= 1'b1;
    end
  end

  // Outputs are gated by reset so an access drops the moment reset asserts.
  always_comb begin
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    CPU_MIO       = 1'b0;
    IorD          = 1'b0;
    IRWrite       = 1'b0;
    RegWrite      = 1'b0;
    ALUSrcA       = 1'b0;
    PCWrite       = 1'b0;
    PCWriteCond   = 1'b0;
    Branch        = 1'b0;
    RegDst        = 2'b00;
    MemtoReg      = 2'b00;
    ALUSrcB       = 2'b00;
    PCSource      = 2'b00;
    ALU_operation = 3'b000;
    EPCWrite      = 1'b0;
    VecSel        = 1'b0;
    int_ack       = 1'b0;
    if (reset) begin
      case (r_state)
        S_IF: begin
          MemRead       = 1'b1;
          CPU_MIO       = 1'b1;
          ALUSrcB       = 2'b01;
          ALU_operation = ALU_ADD;
          IRWrite       = MIO_ready;
          PCWrite       = MIO_ready;
        end
        S_ID: begin
          ALUSrcB       = 2'b11;
          ALU_operation = ALU_ADD;
        end
        S_MA: begin
          ALUSrcA       = 1'b1;
          ALUSrcB       = 2'b10;
          ALU_operation = ALU_ADD;
        end
        S_MRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
          CPU_MIO = 1'b1;
        end
        S_MWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
          CPU_MIO  = 1'b1;
        end
        S_MWB: begin
          RegWrite = 1'b1;
          MemtoReg = 2'b01;
        end
        S_EXR: begin
          ALUSrcA = 1'b1;
          case (w_funct)
            6'h20:   ALU_operation = ALU_ADD;
            6'h22:   ALU_operation = ALU_SUB;
            6'h24:   ALU_operation = ALU_AND;
            6'h25:   ALU_operation = ALU_OR;
            6'h27:   ALU_operation = ALU_NOR;
            6'h2A:   ALU_operation = ALU_SLT;
            6'h02:   ALU_operation = ALU_SRL;
            6'h26:   ALU_operation = ALU_XOR;
            default: ALU_operation = ALU_ADD;
          endcase
        end
        S_WBR: begin
          RegDst   = 2'b01;
          RegWrite = !(overflow && ((w_funct == 6'h20) || (w_funct == 6'h22)));
        end
        S_EXI: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          case (w_op)
            6'h0C:   ALU_operation = ALU_AND;
            6'h0D:   ALU_operation = ALU_OR;
            6'h0A:   ALU_operation = ALU_SLT;
            default: ALU_operation = ALU_ADD;
          endcase
        end
        S_WBI:   RegWrite = !(overflow && (w_op == 6'h08));
        S_LUI: begin
          RegWrite = 1'b1;
          MemtoReg = 2'b11;
        end
        S_BEQ, S_BNE: begin
          ALUSrcA       = 1'b1;
          ALU_operation = ALU_SUB;
          PCWriteCond   = 1'b1;
          PCSource      = 2'b01;
          Branch        = (r_state == S_BEQ);
        end
        S_J: begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
        end
        S_JAL: begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
          RegWrite = 1'b1;
          RegDst   = 2'b10;
          MemtoReg = 2'b10;
        end
        S_JR: begin
          PCWrite       = 1'b1;
          ALUSrcA       = 1'b1;
          ALU_operation = ALU_ADD;
        end
        S_INT: begin
          EPCWrite = 1'b1;
          PCWrite  = 1'b1;
          PCSource = 2'b11;
          VecSel   = 1'b1;
          int_ack  = 1'b1;
        end
        S_ERET: begin
          PCWrite  = 1'b1;
          PCSource = 2'b11;
        end
        default: ;
      endcase
    end
  end

  assign bus_fault = r_bus_fault;
  assign state_out = STATE_W'(r_state);

endmodule

// File: tb/tb_mc_ctrl_int.sv
// Directed bench for mc_ctrl_int: fetch/decode paths, overflow suppression,
// branches, interrupt entry/return and wait-state timeout.
module tb_mc_ctrl_int;

  logic        clk;
  logic        reset;
  logic [31:0] Inst_in;
  logic        zero, overflow, MIO_ready, INT;
  logic        MemRead, MemWrite, CPU_MIO, IorD, IRWrite, RegWrite, ALUSrcA;
  logic        PCWrite, PCWriteCond, Branch;
  logic [1:0]  RegDst, MemtoReg, ALUSrcB, PCSource;
  logic [2:0]  ALU_operation;
  logic        EPCWrite, VecSel, int_ack, bus_fault;
  logic [4:0]  state_out;

  int total = 0;
  int bad   = 0;

  mc_ctrl_int #(.STATE_W(5), .WAIT_MAX(16), .INT_EN_RST(1'b1)) dut (
    .clk(clk), .reset(reset), .Inst_in(Inst_in), .zero(zero),
    .overflow(overflow), .MIO_ready(MIO_ready), .INT(INT),
    .MemRead(MemRead), .MemWrite(MemWrite), .CPU_MIO(CPU_MIO), .IorD(IorD),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .Branch(Branch),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcB(ALUSrcB),
    .PCSource(PCSource), .ALU_operation(ALU_operation),
    .EPCWrite(EPCWrite), .VecSel(VecSel), .int_ack(int_ack),
    .bus_fault(bus_fault), .state_out(state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0; Inst_in = 32'h0; zero = 1'b0; overflow = 1'b0;
    MIO_ready = 1'b0; INT = 1'b0;
    repeat (3) tick();
    chk("rst_state", 32'(state_out), 32'd0);
    chk("rst_fault", 32'(bus_fault), 32'd0);
    MIO_ready = 1'b1; Inst_in = 32'h8C020004;
    #1;
    chk("rst_memread_gated", 32'(MemRead), 32'd0);
    chk("rst_pcwrite_gated", 32'(PCWrite), 32'd0);

    // lw: IF -> ID -> MA -> MRD -> MWB -> IF
    reset = 1'b1; #1;
    chk("lw_if_state", 32'(state_out), 32'd0);
    chk("lw_if_memread", 32'(MemRead), 32'd1);
    chk("lw_if_irwrite", 32'(IRWrite), 32'd1);
    chk("lw_if_alusrcb", 32'(ALUSrcB), 32'd1);
    chk("lw_if_aluop", 32'(ALU_operation), 32'd2);
    tick(); chk("lw_id_state", 32'(state_out), 32'd1);
    chk("lw_id_alusrcb", 32'(ALUSrcB), 32'd3);
    tick(); chk("lw_ma_state", 32'(state_out), 32'd2);
    chk("lw_ma_alusrcb", 32'(ALUSrcB), 32'd2);
    tick(); chk("lw_mrd_state", 32'(state_out), 32'd3);
    chk("lw_mrd_iord", 32'(IorD), 32'd1);
    chk("lw_mrd_regwrite", 32'(RegWrite), 32'd0);
    chk("lw_mrd_memwrite", 32'(MemWrite), 32'd0);
    tick(); chk("lw_mwb_state", 32'(state_out), 32'd4);
    chk("lw_mwb_regwrite", 32'(RegWrite), 32'd1);
    chk("lw_mwb_memtoreg", 32'(MemtoReg), 32'd1);
    tick(); chk("lw_back_if", 32'(state_out), 32'd0);

    // add with and without overflow in WBR
    Inst_in = 32'h00221820;
    tick(); chk("add_id", 32'(state_out), 32'd1);
    tick(); chk("add_exr", 32'(state_out), 32'd6);
    chk("add_exr_aluop", 32'(ALU_operation), 32'd2);
    overflow = 1'b1;
    tick(); chk("add_wbr", 32'(state_out), 32'd7);
    chk("add_ovf_regwrite", 32'(RegWrite), 32'd0);
    overflow = 1'b0; #1;
    chk("add_noovf_regwrite", 32'(RegWrite), 32'd1);
    chk("add_regdst", 32'(RegDst), 32'd1);
    tick(); chk("add_back_if", 32'(state_out), 32'd0);

    // beq then bne
    Inst_in = 32'h10220003; zero = 1'b1;
    tick(); tick();
    chk("beq_state", 32'(state_out), 32'd8);
    chk("beq_pcwc", 32'(PCWriteCond), 32'd1);
    chk("beq_branch", 32'(Branch), 32'd1);
    chk("beq_pcsrc", 32'(PCSource), 32'd1);
    chk("beq_aluop", 32'(ALU_operation), 32'd6);
    tick(); chk("beq_back_if", 32'(state_out), 32'd0);
    Inst_in = 32'h14220003; zero = 1'b0;
    tick(); tick();
    chk("bne_state", 32'(state_out), 32'd9);
    chk("bne_branch", 32'(Branch), 32'd0);
    chk("bne_pcwc", 32'(PCWriteCond), 32'd1);
    tick(); chk("bne_back_if", 32'(state_out), 32'd0);

    // interrupt raised during EXR, taken after WBR
    Inst_in = 32'h00221820;
    tick(); tick();
    chk("int_exr", 32'(state_out), 32'd6);
    INT = 1'b1;
    tick(); INT = 1'b0;
    chk("int_wbr", 32'(state_out), 32'd7);
    tick(); chk("int_state", 32'(state_out), 32'd16);
    chk("int_epcwrite", 32'(EPCWrite), 32'd1);
    chk("int_pcwrite", 32'(PCWrite), 32'd1);
    chk("int_pcsrc", 32'(PCSource), 32'd3);
    chk("int_vecsel", 32'(VecSel), 32'd1);
    chk("int_ack", 32'(int_ack), 32'd1);
    tick(); chk("int_back_if", 32'(state_out), 32'd0);
    chk("int_ack_pulse", 32'(int_ack), 32'd0);

    // second request masked while IE=0
    INT = 1'b1;
    tick(); INT = 1'b0;
    tick(); tick();
    chk("int2_wbr", 32'(state_out), 32'd7);
    tick(); chk("int2_masked", 32'(state_out), 32'd0);

    // ERET re-enables; held request is taken at the next completion
    Inst_in = 32'h42000018;
    tick(); tick();
    chk("eret_state", 32'(state_out), 32'd17);
    chk("eret_pcsrc", 32'(PCSource), 32'd3);
    chk("eret_vecsel", 32'(VecSel), 32'd0);
    chk("eret_pcwrite", 32'(PCWrite), 32'd1);
    tick(); chk("eret_back_if", 32'(state_out), 32'd0);
    Inst_in = 32'h08000000;
    tick(); tick();
    chk("j_state", 32'(state_out), 32'd10);
    chk("j_pcsrc", 32'(PCSource), 32'd2);
    tick(); chk("int3_taken", 32'(state_out), 32'd16);
    tick(); chk("int3_back_if", 32'(state_out), 32'd0);

    // MRD completes on the 16th wait cycle: no fault
    Inst_in = 32'h8C020004;
    tick(); tick();
    MIO_ready = 1'b0;
    tick(); chk("mrd_enter", 32'(state_out), 32'd3);
    repeat (15) tick();
    chk("mrd_cycle16_state", 32'(state_out), 32'd3);
    chk("mrd_cycle16_fault", 32'(bus_fault), 32'd0);
    MIO_ready = 1'b1;
    tick(); chk("mrd_late_mwb", 32'(state_out), 32'd4);
    chk("mrd_late_nofault", 32'(bus_fault), 32'd0);
    tick(); chk("mrd_late_back_if", 32'(state_out), 32'd0);

    // IF timeout after 16 wait cycles
    MIO_ready = 1'b0;
    repeat (15) tick();
    chk("if_wait15_state", 32'(state_out), 32'd0);
    chk("if_wait15_fault", 32'(bus_fault), 32'd0);
    tick(); chk("fault_state", 32'(state_out), 32'd18);
    chk("fault_flag", 32'(bus_fault), 32'd1);
    chk("fault_memread", 32'(MemRead), 32'd0);
    MIO_ready = 1'b1; INT = 1'b1;
    tick(); tick();
    chk("fault_sticky_state", 32'(state_out), 32'd18);
    chk("fault_sticky_flag", 32'(bus_fault), 32'd1);
    chk("fault_no_intack", 32'(int_ack), 32'd0);
    INT = 1'b0;
    reset = 1'b0; #1;
    chk("fault_rst_state", 32'(state_out), 32'd0);
    chk("fault_rst_flag", 32'(bus_fault), 32'd0);
    tick(); reset = 1'b1;

    // asynchronous reset mid-access drops MemRead at once
    MIO_ready = 1'b1;
    tick(); tick();
    MIO_ready = 1'b0;
    tick(); chk("async_mrd", 32'(state_out), 32'd3);
    chk("async_mrd_memread", 32'(MemRead), 32'd1);
    #2 reset = 1'b0; #1;
    chk("async_memread_drop", 32'(MemRead), 32'd0);
    chk("async_state", 32'(state_out), 32'd0);
    tick(); reset = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
